// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// counter sizing derived from the hold/gap parameters.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to reach HOLD_CYC-1 and GAP_CYC-1; cleared on every release.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    return $clog2(max_int(hold_cyc, gap_cyc) + 1);
  endfunction

endpackage

// File: rtl/reset_seq_next_tgt.sv
// Picks the lowest still-asserted target channel (one-hot) and flags whether
// it is the final one of the sequence.
module reset_seq_next_tgt #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] target,
  input  logic [NUM_CH-1:0] released,
  output logic [NUM_CH-1:0] next_bit,
  output logic              none_left,
  output logic              is_last
);

  logic [NUM_CH-1:0] pending;

  // Two's-complement trick isolates the lowest set bit, which is also the
  // lowest index above every channel already released.
  always_comb begin
    pending   = target & ~released;
    next_bit  = pending & (~pending + NUM_CH'(1));
    none_left = (pending == '0);
    is_last   = ((pending & ~next_bit) == '0);
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds targeted reset lines for HOLD_CYC
// cycles, then releases them in ascending order GAP_CYC cycles apart.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              seq_done
);

  localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0] rel_q, rel_d;
  logic [NUM_CH-1:0] rst_out_d;
  logic              busy_d, done_d;
  logic [NUM_CH-1:0] next_bit;
  logic              none_left, is_last;
  logic              fire;

  reset_seq_next_tgt #(.NUM_CH(NUM_CH)) u_next_tgt (
    .target    (tgt_q),
    .released  (rel_q),
    .next_bit  (next_bit),
    .none_left (none_left),
    .is_last   (is_last)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    rel_d     = rel_q;
    rst_out_d = rst_out;
    busy_d    = busy;
    done_d    = 1'b0;
    fire      = 1'b0;

    case (state_q)
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) fire = 1'b1;
        else                            cnt_d = cnt_q + CW'(1);
      end
      RELEASE: begin
        if (cnt_q == CW'(GAP_CYC - 1)) fire = 1'b1;
        else                           cnt_d = cnt_q + CW'(1);
      end
      default: begin
        if (soft_rst && (ch_mask != '0)) begin
          tgt_d     = ch_mask;
          rel_d     = '0;
          rst_out_d = rst_out | ch_mask;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = HOLD;
        end
      end
    endcase

    // An empty pending set cannot arise from reachable states; fall back to IDLE.
    if (state_q != IDLE && none_left) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (fire) begin
      rst_out_d = rst_out & ~next_bit;
      rel_d     = rel_q | next_bit;
      cnt_d     = '0;
      if (is_last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      tgt_q    <= '1;
      rel_q    <= '0;
      rst_out  <= '1;
      busy     <= 1'b1;
      seq_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      rel_q    <= rel_d;
      rst_out  <= rst_out_d;
      busy     <= busy_d;
      seq_done <= done_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default config plus two parameter
// variants, all driven from one linear initial block.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_rst;
  logic [3:0] ch_mask;
  logic [3:0] rst_out;
  logic       busy, seq_done;

  logic       rst_b;
  logic [0:0] mask1;
  logic [0:0] rst_out1;
  logic       busy1, done1;
  logic [7:0] mask8;
  logic [7:0] rst_out8;
  logic       busy8, done8;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(4), .HOLD_CYC(8), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .ch_mask(ch_mask),
    .rst_out(rst_out), .busy(busy), .seq_done(seq_done)
  );

  reset_sequencer #(.NUM_CH(1), .HOLD_CYC(1), .GAP_CYC(1)) dut1 (
    .clk(clk), .rst(rst_b), .soft_rst(1'b0), .ch_mask(mask1),
    .rst_out(rst_out1), .busy(busy1), .seq_done(done1)
  );

  reset_sequencer #(.NUM_CH(8), .HOLD_CYC(3), .GAP_CYC(2)) dut8 (
    .clk(clk), .rst(rst_b), .soft_rst(1'b0), .ch_mask(mask8),
    .rst_out(rst_out8), .busy(busy8), .seq_done(done8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] e_out,
                            input logic e_busy, input logic e_done);
    check({tag, ".rst_out"},  32'(rst_out),  32'(e_out));
    check({tag, ".busy"},     32'(busy),     32'(e_busy));
    check({tag, ".seq_done"}, 32'(seq_done), 32'(e_done));
  endtask

  // Power-on pattern for the default config: channels fall at n=8,12,16,20.
  function automatic logic [3:0] po_exp(input int n);
    int c;
    c = (n >= 8) ? ((n - 8) / 4 + 1) : 0;
    if (c > 4) c = 4;
    return 4'b1111 << c;
  endfunction

  initial begin
    logic [3:0] e;
    logic [7:0] e8;
    int         c8;

    rst = 1'b1; soft_rst = 1'b0; ch_mask = '0;
    rst_b = 1'b1; mask1 = '0; mask8 = '0;

    repeat (3) step();
    check_main("reset", 4'b1111, 1'b1, 1'b0);
    rst = 1'b0;

    // Power-on sequence interrupted by rst at n=14.
    for (int n = 1; n <= 14; n++) begin
      step();
      check_main($sformatf("po1.n%0d", n), po_exp(n), 1'b1, 1'b0);
    end
    rst = 1'b1;
    step();
    check_main("midrst", 4'b1111, 1'b1, 1'b0);
    rst = 1'b0;

    // Full restart; a soft request at n=5 while busy must be ignored.
    for (int n = 1; n <= 21; n++) begin
      if (n == 5) begin soft_rst = 1'b1; ch_mask = 4'b0001; end
      step();
      soft_rst = 1'b0; ch_mask = '0;
      check_main($sformatf("po2.n%0d", n), po_exp(n), (n < 20), (n == 20));
    end

    // Soft request with an empty mask in IDLE does nothing.
    soft_rst = 1'b1; ch_mask = 4'b0000;
    step();
    check_main("mask0.a", 4'b0000, 1'b0, 1'b0);
    step();
    soft_rst = 1'b0;
    check_main("mask0.b", 4'b0000, 1'b0, 1'b0);

    // Soft reset of channels 1 and 3; later mask changes must not matter.
    soft_rst = 1'b1; ch_mask = 4'b1010;
    step();
    check_main("soft.accept", 4'b1010, 1'b1, 1'b0);
    soft_rst = 1'b0; ch_mask = 4'b1111;
    for (int n = 1; n <= 13; n++) begin
      e = (n < 8) ? 4'b1010 : (n < 12) ? 4'b1000 : 4'b0000;
      step();
      check_main($sformatf("soft.n%0d", n), e, (n < 12), (n == 12));
    end

    // soft_rst held high: next accept only on the edge after seq_done.
    soft_rst = 1'b1; ch_mask = 4'b0110;
    step();
    check_main("b2b.accept", 4'b0110, 1'b1, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      e = (n < 8) ? 4'b0110 : (n < 12) ? 4'b0100 : 4'b0000;
      step();
      check_main($sformatf("b2b.n%0d", n), e, (n < 12), (n == 12));
    end
    step();
    check_main("b2b.reaccept", 4'b0110, 1'b1, 1'b0);
    soft_rst = 1'b0;

    // Parameter variants, both under the shared rst_b.
    check("p1.reset.rst_out", 32'(rst_out1), 32'h1);
    check("p1.reset.busy",    32'(busy1),    32'h1);
    check("p8.reset.rst_out", 32'(rst_out8), 32'hff);
    check("p8.reset.busy",    32'(busy8),    32'h1);
    rst_b = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      step();
      check($sformatf("p1.n%0d.rst_out", n), 32'(rst_out1), 32'h0);
      check($sformatf("p1.n%0d.busy", n),    32'(busy1),    32'h0);
      check($sformatf("p1.n%0d.done", n),    32'(done1),    32'(n == 1));
      c8 = (n >= 3) ? ((n - 3) / 2 + 1) : 0;
      if (c8 > 8) c8 = 8;
      e8 = 8'hff << c8;
      check($sformatf("p8.n%0d.rst_out", n), 32'(rst_out8), 32'(e8));
      check($sformatf("p8.n%0d.busy", n),    32'(busy8),    32'(n < 17));
      check($sformatf("p8.n%0d.done", n),    32'(done8),    32'(n == 17));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
